// File: rtl/trg_sci_pkt_parser.sv
// Trigger science-data packet parser: drains the FWFT byte FIFO, validates 16-byte frames,
// and presents each trigger record on a valid/ready handshake with good/error/sequence statistics.
module trg_sci_pkt_parser #(
    parameter logic [7:0]  HDR0   = 8'hEB,
    parameter logic [7:0]  HDR1   = 8'h90,
    parameter logic [7:0]  TAIL   = 8'hAA,
    parameter int unsigned TO_CYC = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rd_enb_in,
    input  logic [7:0]  fifo_data_in,
    input  logic        fifo_empty_in,
    output logic        fifo_rd_out,
    output logic        pkt_valid_out,
    input  logic        pkt_ready_in,
    output logic [15:0] eff_trg_cnt_out,
    output logic [7:0]  logic_grp_oe_out,
    output logic [15:0] hit_sig_stus_out,
    output logic [4:0]  W_logic_all_grp_result_out,
    output logic [7:0]  trg_mode_mip1_out,
    output logic [7:0]  trg_mode_mip2_out,
    output logic [7:0]  trg_mode_gm1_out,
    output logic [7:0]  trg_mode_gm2_out,
    output logic [7:0]  trg_mode_ubs_out,
    output logic        chk_err_out,
    output logic        seq_err_out,
    output logic [15:0] pkt_cnt_out,
    output logic [15:0] err_cnt_out
);

    typedef enum logic [2:0] {S_HUNT0, S_HUNT1, S_BODY, S_TAIL, S_OUT} state_e;

    typedef struct packed {
        logic [15:0] cnt;
        logic [7:0]  oe;
        logic [15:0] hit;
        logic [4:0]  wres;
        logic [7:0]  mip1;
        logic [7:0]  mip2;
        logic [7:0]  gm1;
        logic [7:0]  gm2;
        logic [7:0]  ubs;
    } rec_t;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] to_q, to_d;
    rec_t        hold_q, hold_d;
    rec_t        rec_q;
    logic [15:0] prev_cnt_q;
    logic        prev_vld_q;
    logic        chk_err_q, seq_err_q;
    logic [15:0] pkt_cnt_q, err_cnt_q;

    logic pop, in_frame, load, err_evt, accept, seq_gap;

    assign in_frame = (state_q == S_HUNT1) || (state_q == S_BODY) || (state_q == S_TAIL);
    // Gated by reset so the pop strobe is low the instant reset asserts.
    assign pop      = rst_in & rd_enb_in & ~fifo_empty_in & (state_q != S_OUT);
    assign seq_gap  = prev_vld_q && (hold_q.cnt != prev_cnt_q + 16'd1);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        csum_d  = csum_q;
        hold_d  = hold_q;
        to_d    = to_q;
        load    = 1'b0;
        err_evt = 1'b0;
        accept  = 1'b0;

        case (state_q)
            S_HUNT0: if (pop && fifo_data_in == HDR0) state_d = S_HUNT1;
            S_HUNT1: if (pop) begin
                if (fifo_data_in == HDR1) begin
                    state_d = S_BODY;
                    idx_d   = 4'd2;
                    sum_d   = 8'h00;
                end else if (fifo_data_in != HDR0) begin
                    state_d = S_HUNT0;
                end
            end
            S_BODY: if (pop) begin
                case (idx_q)
                    4'd2:    hold_d.cnt[15:8] = fifo_data_in;
                    4'd3:    hold_d.cnt[7:0]  = fifo_data_in;
                    4'd4:    hold_d.oe        = fifo_data_in;
                    4'd5:    hold_d.hit[15:8] = fifo_data_in;
                    4'd6:    hold_d.hit[7:0]  = fifo_data_in;
                    4'd7:    hold_d.wres      = fifo_data_in[4:0];
                    4'd8:    hold_d.mip1      = fifo_data_in;
                    4'd9:    hold_d.mip2      = fifo_data_in;
                    4'd10:   hold_d.gm1       = fifo_data_in;
                    4'd11:   hold_d.gm2       = fifo_data_in;
                    4'd12:   hold_d.ubs       = fifo_data_in;
                    4'd14:   csum_d           = fifo_data_in;
                    default: ;
                endcase
                // Byte 14 is the transmitted checksum, not part of the sum.
                if (idx_q != 4'd14) sum_d = sum_q + fifo_data_in;
                if (idx_q == 4'd14) state_d = S_TAIL;
                else                idx_d   = idx_q + 4'd1;
            end
            S_TAIL: if (pop) begin
                if (fifo_data_in == TAIL && sum_q == csum_q) begin
                    state_d = S_OUT;
                    load    = 1'b1;
                end else begin
                    state_d = S_HUNT0;
                    err_evt = 1'b1;
                end
            end
            S_OUT: if (pkt_ready_in) begin
                state_d = S_HUNT0;
                accept  = 1'b1;
            end
            default: state_d = S_HUNT0;
        endcase

        // Idle timeout only runs while enabled and inside a frame; it never coincides with a pop.
        if (!in_frame) begin
            to_d = 16'd0;
        end else if (rd_enb_in) begin
            if (pop) begin
                to_d = 16'd0;
            end else if (to_q == 16'(TO_CYC - 1)) begin
                to_d    = 16'd0;
                state_d = S_HUNT0;
                err_evt = 1'b1;
            end else begin
                to_d = to_q + 16'd1;
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_HUNT0;
            idx_q      <= 4'd0;
            sum_q      <= 8'h00;
            csum_q     <= 8'h00;
            to_q       <= 16'd0;
            hold_q     <= '0;
            rec_q      <= '0;
            prev_cnt_q <= 16'd0;
            prev_vld_q <= 1'b0;
            chk_err_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            pkt_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            csum_q    <= csum_d;
            to_q      <= to_d;
            hold_q    <= hold_d;
            chk_err_q <= err_evt;
            seq_err_q <= load & seq_gap;
            if (load) begin
                rec_q      <= hold_q;
                prev_cnt_q <= hold_q.cnt;
                prev_vld_q <= 1'b1;
            end
            if (accept) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (err_evt && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign fifo_rd_out                = pop;
    assign pkt_valid_out              = (state_q == S_OUT);
    assign eff_trg_cnt_out            = rec_q.cnt;
    assign logic_grp_oe_out           = rec_q.oe;
    assign hit_sig_stus_out           = rec_q.hit;
    assign W_logic_all_grp_result_out = rec_q.wres;
    assign trg_mode_mip1_out          = rec_q.mip1;
    assign trg_mode_mip2_out          = rec_q.mip2;
    assign trg_mode_gm1_out           = rec_q.gm1;
    assign trg_mode_gm2_out           = rec_q.gm2;
    assign trg_mode_ubs_out           = rec_q.ubs;
    assign chk_err_out                = chk_err_q;
    assign seq_err_out                = seq_err_q;
    assign pkt_cnt_out                = pkt_cnt_q;
    assign err_cnt_out                = err_cnt_q;

endmodule

// File: tb/tb_trg_sci_pkt_parser.sv
// Self-checking bench for trg_sci_pkt_parser: directed frame table, stall/timeout/reset
// sequences, and randomized frame streams checked against a frame-level reference model.
module tb_trg_sci_pkt_parser;

    typedef struct packed {
        logic [15:0] cnt;
        logic [7:0]  oe;
        logic [15:0] hit;
        logic [4:0]  wres;
        logic [7:0]  mip1;
        logic [7:0]  mip2;
        logic [7:0]  gm1;
        logic [7:0]  gm2;
        logic [7:0]  ubs;
    } rec_t;

    typedef struct {
        logic [15:0]  pre;
        int           npre;
        logic [127:0] frame;
        bit           good;
        bit           seq;
        rec_t         exp;
    } vec_t;

    localparam logic [127:0] FA  = 128'hEB90_1234_0909_6F14_0305_0711_2100_1CAA;
    localparam logic [127:0] FB  = 128'hEB90_1244_0909_6F14_0305_0711_2100_2CAA;
    localparam logic [127:0] FC  = 128'hEB90_1234_0909_6F14_0305_0711_2100_1DAA;
    localparam logic [127:0] FE  = 128'hEB90_1235_0909_6F14_0305_0711_2100_1DAB;
    localparam logic [127:0] FF  = 128'hEB90_1235_0909_6F14_0305_0711_2100_1DAA;
    localparam rec_t RA = {16'h1234, 8'h09, 16'h096F, 5'h14, 8'h03, 8'h05, 8'h07, 8'h11, 8'h21};
    localparam rec_t RB = {16'h1244, 8'h09, 16'h096F, 5'h14, 8'h03, 8'h05, 8'h07, 8'h11, 8'h21};
    localparam rec_t RF = {16'h1235, 8'h09, 16'h096F, 5'h14, 8'h03, 8'h05, 8'h07, 8'h11, 8'h21};

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rd_enb_in, pkt_ready_in;
    logic [7:0]  fifo_data_in = 8'h00;
    logic        fifo_empty_in = 1'b1;
    logic        fifo_rd_out, pkt_valid_out, chk_err_out, seq_err_out;
    logic [15:0] eff_trg_cnt_out, hit_sig_stus_out, pkt_cnt_out, err_cnt_out;
    logic [7:0]  logic_grp_oe_out, trg_mode_mip1_out, trg_mode_mip2_out;
    logic [7:0]  trg_mode_gm1_out, trg_mode_gm2_out, trg_mode_ubs_out;
    logic [4:0]  W_logic_all_grp_result_out;

    trg_sci_pkt_parser dut (
        .clk_in(clk_in), .rst_in(rst_in), .rd_enb_in(rd_enb_in),
        .fifo_data_in(fifo_data_in), .fifo_empty_in(fifo_empty_in), .fifo_rd_out(fifo_rd_out),
        .pkt_valid_out(pkt_valid_out), .pkt_ready_in(pkt_ready_in),
        .eff_trg_cnt_out(eff_trg_cnt_out), .logic_grp_oe_out(logic_grp_oe_out),
        .hit_sig_stus_out(hit_sig_stus_out), .W_logic_all_grp_result_out(W_logic_all_grp_result_out),
        .trg_mode_mip1_out(trg_mode_mip1_out), .trg_mode_mip2_out(trg_mode_mip2_out),
        .trg_mode_gm1_out(trg_mode_gm1_out), .trg_mode_gm2_out(trg_mode_gm2_out),
        .trg_mode_ubs_out(trg_mode_ubs_out), .chk_err_out(chk_err_out), .seq_err_out(seq_err_out),
        .pkt_cnt_out(pkt_cnt_out), .err_cnt_out(err_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    rec_t dut_rec;
    assign dut_rec = {eff_trg_cnt_out, logic_grp_oe_out, hit_sig_stus_out, W_logic_all_grp_result_out,
                      trg_mode_mip1_out, trg_mode_mip2_out, trg_mode_gm1_out, trg_mode_gm2_out,
                      trg_mode_ubs_out};

    // Input drive: directed values, or per-cycle random values in random mode.
    logic rd_dir = 1'b1, rdy_dir = 1'b1, rand_mode = 1'b0;
    logic rnd_rd = 1'b1, rnd_rdy = 1'b1, rnd_gap = 1'b0;
    assign rd_enb_in    = rd_dir & (rand_mode ? rnd_rd : 1'b1);
    assign pkt_ready_in = rand_mode ? rnd_rdy : rdy_dir;

    int n_cmp = 0, n_bad = 0;
    int n_chk = 0, n_seq = 0, n_vld_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FWFT FIFO model
    logic [7:0] fq[$];
    logic       pop_seen = 1'b0;

    function automatic void refresh();
        fifo_empty_in = (fq.size() == 0) || (rand_mode && rnd_gap);
        fifo_data_in  = (fq.size() != 0) ? fq[0] : 8'h00;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        refresh();
    endtask

    task automatic push_bytes(input logic [127:0] f, input int n);
        for (int i = 0; i < n; i++) push_byte(f[127 - 8*i -: 8]);
    endtask

    always @(posedge clk_in) pop_seen <= fifo_rd_out;

    always @(negedge clk_in) begin
        if (pop_seen && fq.size() != 0) void'(fq.pop_front());
        rnd_gap = ($urandom_range(0, 99) < 20);
        rnd_rd  = ($urandom_range(0, 99) < 85);
        rnd_rdy = ($urandom_range(0, 99) < 70);
        refresh();
    end

    // Frame-level reference model
    rec_t        exp_q[$];
    bit          exp_seq_q[$];
    logic [15:0] m_prev = 16'h0;
    bit          m_prev_vld = 0;
    int          exp_pkt = 0, exp_err = 0, exp_seq = 0;

    function automatic logic [127:0] make_frame(input rec_t r);
        logic [7:0]   b [16];
        logic [7:0]   s;
        logic [127:0] f;
        b[0] = 8'hEB;  b[1] = 8'h90;  b[2] = r.cnt[15:8]; b[3] = r.cnt[7:0];
        b[4] = r.oe;   b[5] = r.hit[15:8]; b[6] = r.hit[7:0]; b[7] = {3'b000, r.wres};
        b[8] = r.mip1; b[9] = r.mip2; b[10] = r.gm1; b[11] = r.gm2; b[12] = r.ubs; b[13] = 8'h00;
        s = 8'h00;
        for (int i = 2; i <= 13; i++) s = s + b[i];
        b[14] = s;
        b[15] = 8'hAA;
        for (int i = 0; i < 16; i++) f[127 - 8*i -: 8] = b[i];
        return f;
    endfunction

    function automatic bit model_seq(input logic [15:0] c);
        return m_prev_vld && (c != 16'(m_prev + 16'd1));
    endfunction

    task automatic push_exp(input rec_t r, input bit s);
        exp_q.push_back(r);
        exp_seq_q.push_back(s);
        m_prev     = r.cnt;
        m_prev_vld = 1;
        exp_pkt++;
        if (s) exp_seq++;
    endtask

    // Output monitor, sampled after the negedge input updates have settled.
    logic vld_prev = 1'b0;
    rec_t rec_prev = '0;
    always @(negedge clk_in) begin
        #2;
        if (rst_in) begin
            if (chk_err_out) n_chk++;
            if (seq_err_out) begin
                n_seq++;
                check("seq_err_on_valid_rise", pkt_valid_out & ~vld_prev, 1'b1);
            end
            if (pkt_valid_out) begin
                n_vld_cyc++;
                check("no_pop_while_valid", fifo_rd_out, 1'b0);
                if (!vld_prev) begin
                    check("record_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("seq_err_flag", seq_err_out, exp_seq_q[0]);
                end else begin
                    check("fields_stable", dut_rec, rec_prev);
                end
                if (pkt_ready_in && exp_q.size() != 0) begin
                    check("record_fields", dut_rec, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_seq_q.pop_front());
                end
            end
            vld_prev <= pkt_valid_out;
            rec_prev <= dut_rec;
        end else begin
            vld_prev <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        fq.delete();
        refresh();
        exp_q.delete();
        exp_seq_q.delete();
        m_prev_vld = 0;
        exp_pkt = 0; exp_err = 0; exp_seq = 0;
        #1;
        check("reset_outputs",
              {fifo_rd_out, pkt_valid_out, dut_rec, chk_err_out, seq_err_out, pkt_cnt_out, err_cnt_out}, '0);
        repeat (3) @(negedge clk_in);
        n_chk = 0; n_seq = 0;
        rst_in = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || pkt_valid_out) && c < budget) begin
            @(negedge clk_in);
            c++;
        end
        check("drain_done", fq.size() + exp_q.size(), 0);
        repeat (3) @(negedge clk_in);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt"},    pkt_cnt_out, exp_pkt);
        check({tag, "_err_cnt"},    err_cnt_out, exp_err);
        check({tag, "_chk_pulses"}, n_chk, exp_err);
        check({tag, "_seq_pulses"}, n_seq, exp_seq);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [6];
        int           v0, n, kind, npre;
        rec_t         r, r2;
        logic [127:0] f;
        logic [7:0]   g;

        tbl[0] = '{16'h0000, 0, FA, 1'b1, 1'b0, RA};
        tbl[1] = '{16'h0000, 0, FB, 1'b1, 1'b1, RB};
        tbl[2] = '{16'h0000, 0, FC, 1'b0, 1'b0, '0};
        tbl[3] = '{16'h00EB, 2, FA, 1'b1, 1'b1, RA};
        tbl[4] = '{16'h0000, 0, FE, 1'b0, 1'b0, '0};
        tbl[5] = '{16'h0000, 0, FF, 1'b1, 1'b0, RF};

        do_reset();
        repeat (2) @(negedge clk_in);
        check("idle_after_reset", {pkt_valid_out, fifo_rd_out, pkt_cnt_out, err_cnt_out}, '0);

        // Directed frame table
        for (int i = 0; i < 6; i++) begin
            v0 = n_vld_cyc;
            if (tbl[i].npre == 2) push_byte(tbl[i].pre[15:8]);
            if (tbl[i].npre >= 1) push_byte(tbl[i].pre[7:0]);
            push_bytes(tbl[i].frame, 16);
            if (tbl[i].good) push_exp(tbl[i].exp, tbl[i].seq);
            else exp_err++;
            wait_drain(300);
            check("vec_valid_cycles", n_vld_cyc - v0, tbl[i].good);
            check_counts("vec");
        end

        // Back-pressure with a second frame queued
        rdy_dir = 1'b0;
        r  = RF; r.cnt  = 16'h1236;
        r2 = RF; r2.cnt = 16'h1237; r2.ubs = 8'h5A;
        push_bytes(make_frame(r), 16);
        push_bytes(make_frame(r2), 16);
        push_exp(r, model_seq(r.cnt));
        push_exp(r2, model_seq(r2.cnt));
        n = 0;
        while (!pkt_valid_out && n < 100) begin @(negedge clk_in); n++; end
        check("stall_valid_up", pkt_valid_out, 1'b1);
        repeat (50) @(negedge clk_in);
        check("stall_fifo_held", fq.size(), 16);
        check("stall_pkt_cnt_held", pkt_cnt_out, exp_pkt - 2);
        check("stall_record", dut_rec, r);
        rdy_dir = 1'b1;
        wait_drain(300);
        check_counts("stall");

        // Idle timeout inside a frame
        push_bytes(FA, 7);
        n = 0;
        while (fq.size() != 0 && n < 50) begin @(negedge clk_in); n++; end
        n = 0;
        while (!chk_err_out && n < 1200) begin @(negedge clk_in); n++; end
        check("timeout_window", (n >= 1022) && (n <= 1026), 1'b1);
        exp_err++;
        repeat (3) @(negedge clk_in);
        check("timeout_no_record", pkt_valid_out, 1'b0);
        check_counts("timeout");
        r = RA; r.cnt = 16'(m_prev + 16'd1);
        push_bytes(make_frame(r), 16);
        push_exp(r, model_seq(r.cnt));
        wait_drain(300);
        check_counts("post_timeout");

        // Reset mid-frame discards the partial record
        push_bytes(FA, 5);
        n = 0;
        while (fq.size() != 0 && n < 50) begin @(negedge clk_in); n++; end
        do_reset();
        r = RB; r.cnt = 16'h0042;
        push_bytes(make_frame(r), 16);
        push_exp(r, model_seq(r.cnt));
        wait_drain(300);
        check_counts("post_reset");

        // Randomized stream with random gaps, enable and back-pressure
        do_reset();
        rand_mode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            npre = $urandom_range(0, 3);
            for (int j = 0; j < npre; j++) begin
                g = 8'($urandom);
                if (g == 8'hEB) g = 8'h00;
                push_byte(g);
            end
            r.cnt  = (m_prev_vld && $urandom_range(0, 1) == 1) ? 16'(m_prev + 16'd1) : 16'($urandom);
            r.oe   = 8'($urandom);   r.hit  = 16'($urandom); r.wres = 5'($urandom);
            r.mip1 = 8'($urandom);   r.mip2 = 8'($urandom);  r.gm1  = 8'($urandom);
            r.gm2  = 8'($urandom);   r.ubs  = 8'($urandom);
            kind = $urandom_range(0, 3);
            if (k == 20) begin r.cnt = 16'hFFFF; kind = 2; end
            if (k == 21) begin r.cnt = 16'h0000; kind = 2; end
            f = make_frame(r);
            if (kind == 0) begin
                f[15:8] = f[15:8] + 8'($urandom_range(1, 255));
                exp_err++;
            end else if (kind == 1) begin
                f[7:0] = 8'hAA ^ 8'($urandom_range(1, 255));
                exp_err++;
            end else begin
                push_exp(r, model_seq(r.cnt));
            end
            push_bytes(f, 16);
        end
        wait_drain(30000);
        rand_mode = 1'b0;
        refresh();
        repeat (3) @(negedge clk_in);
        check_counts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
